dma_desc_sched: RTL and testbench

//  Schedules DMA descriptors from NUM_REQ requesters (e.g. RX/TX channels) through a shared
//  48b x 8 register FIFO (regfifo_48b_8, instantiated beside this block) into one DMA engine.

---
 rtl/dma_desc_sched.sv | 179 +++++++++++++++++
 tb/tb_dma_desc_sched.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_desc_sched.sv
// Descriptor scheduler: round-robin push of requester descriptors into an external 48b FIFO,
// and a pop FSM that hands one descriptor at a time to the DMA engine and routes completions back.
module dma_desc_sched #(
  parameter int NUM_REQ    = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  input  logic [NUM_REQ*48-1:0]  i_req_desc,
  output logic [NUM_REQ-1:0]     o_req_ready,
  output logic                   o_fifo_wr_en,
  output logic [47:0]            o_fifo_din,
  input  logic                   i_fifo_full,
  output logic                   o_fifo_rd_en,
  input  logic [47:0]            i_fifo_dout,
  input  logic                   i_fifo_empty,
  output logic                   o_dma_valid,
  output logic [47:0]            o_dma_desc,
  output logic [1:0]             o_dma_id,
  input  logic                   i_dma_ready,
  input  logic                   i_dma_done,
  output logic [NUM_REQ-1:0]     o_done_vec,
  output logic [NUM_REQ-1:0]     o_drop_vec,
  output logic [7:0]             o_stray_cnt,
  output logic [1:0]             o_dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1; the
  // offering side holds data stable until then (requesters -> grant, o_dma_valid -> i_dma_ready).

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT_DONE = 2'd2} state_t;

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(FIFO_DEPTH);

  function automatic logic [1:0] wrap_inc(input logic [1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return 2'(s);
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (idx == 2'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  state_t          r_state, w_next_state;
  logic [1:0]      r_rr_ptr;
  logic [1:0]      r_idq [FIFO_DEPTH];
  logic [CW-1:0]   r_idq_cnt;
  logic            r_dma_valid;
  logic [47:0]     r_dma_desc;
  logic [1:0]      r_dma_id;
  logic [NUM_REQ-1:0] r_done_vec, r_drop_vec;
  logic [7:0]      r_stray_cnt;

  logic [3:0]      w_valid;
  logic [47:0]     w_desc [4];
  logic            w_grant;
  logic [1:0]      w_winner;
  logic [47:0]     w_win_desc;
  logic            w_win_zero;
  logic            w_fifo_rd;
  logic            w_push, w_pop;
  logic [IW-1:0]   w_wr_idx;

  // Pad requester inputs to four slots so the 2-bit winner index is always in range.
  assign w_valid = 4'(i_req_valid);
  for (genvar g = 0; g < 4; g++) begin : g_desc
    if (g < NUM_REQ) begin : g_on
      assign w_desc[g] = i_req_desc[48*g +: 48];
    end else begin : g_off
      assign w_desc[g] = '0;
    end
  end

  // Scan from the farthest slot back to the nearest so the nearest valid index after rr_ptr wins.
  always_comb begin
    w_grant  = 1'b0;
    w_winner = '0;
    if (rst_n && !i_fifo_full) begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        if (w_valid[wrap_inc(r_rr_ptr, k)]) begin
          w_grant  = 1'b1;
          w_winner = wrap_inc(r_rr_ptr, k);
        end
      end
    end
  end

  assign w_win_desc   = w_desc[w_winner];
  assign w_win_zero   = (w_win_desc[47:32] == 16'd0);
  assign o_req_ready  = w_grant ? onehot(w_winner) : '0;
  assign o_fifo_wr_en = w_grant && !w_win_zero;
  assign o_fifo_din   = o_fifo_wr_en ? w_win_desc : '0;

  always_comb begin
    w_next_state = r_state;
    w_fifo_rd    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!i_fifo_empty) begin
          w_fifo_rd    = 1'b1;
          w_next_state = S_ISSUE;
        end
      end
      S_ISSUE:     if (i_dma_ready) w_next_state = S_WAIT_DONE;
      S_WAIT_DONE: if (i_dma_done)  w_next_state = S_IDLE;
      default:     w_next_state = S_IDLE;
    endcase
  end

  assign o_fifo_rd_en = w_fifo_rd && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= 2'(NUM_REQ - 1);
      r_dma_valid <= 1'b0;
      r_dma_desc  <= '0;
      r_dma_id    <= '0;
      r_done_vec  <= '0;
      r_drop_vec  <= '0;
      r_stray_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_done_vec <= '0;
      r_drop_vec <= '0;
      if (w_grant) begin
        r_rr_ptr <= w_winner;
        if (w_win_zero) r_drop_vec <= onehot(w_winner);
      end
      if (w_fifo_rd) begin
        r_dma_valid <= 1'b1;
        r_dma_desc  <= i_fifo_dout;
        r_dma_id    <= r_idq[0];
      end else if (r_state == S_ISSUE && i_dma_ready) begin
        r_dma_valid <= 1'b0;
      end
      if (i_dma_done) begin
        if (r_state == S_WAIT_DONE) r_done_vec <= onehot(r_dma_id);
        else if (r_stray_cnt != 8'hFF) r_stray_cnt <= r_stray_cnt + 8'd1;
      end
    end
  end

  // ID queue tracks FIFO occupancy one-for-one; on push+pop the new entry lands one slot lower.
  assign w_push   = o_fifo_wr_en;
  assign w_pop    = o_fifo_rd_en;
  assign w_wr_idx = w_pop ? IW'(r_idq_cnt - CW'(1)) : IW'(r_idq_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idq_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_idq[i] <= '0;
    end else begin
      if (w_pop) begin
        for (int i = 0; i < FIFO_DEPTH - 1; i++) r_idq[i] <= r_idq[i+1];
        r_idq[FIFO_DEPTH-1] <= '0;
      end
      if (w_push) r_idq[w_wr_idx] <= w_winner;
      r_idq_cnt <= r_idq_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  assign o_dma_valid = r_dma_valid;
  assign o_dma_desc  = r_dma_desc;
  assign o_dma_id    = r_dma_id;
  assign o_done_vec  = r_done_vec;
  assign o_drop_vec  = r_drop_vec;
  assign o_stray_cnt = r_stray_cnt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dma_desc_sched.sv
// Bench for dma_desc_sched: behavioural FIFO beside the DUT, transaction-level reference model
// (round-robin order, per-descriptor queue, one-outstanding DMA), directed cases then random traffic.
module tb_dma_desc_sched;
  localparam int N = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N*48-1:0]  req_desc = '0;
  logic [N-1:0]     req_ready;
  logic             fifo_wr_en, fifo_rd_en;
  logic [47:0]      fifo_din;
  logic             fifo_full = 1'b0, fifo_empty = 1'b1;
  logic [47:0]      fifo_dout = '0;
  logic             dma_valid;
  logic [47:0]      dma_desc;
  logic [1:0]       dma_id;
  logic             dma_ready = 1'b0, dma_done = 1'b0;
  logic [N-1:0]     done_vec, drop_vec;
  logic [7:0]       stray_cnt;
  logic [1:0]       dbg_state;

  int checks = 0;
  int failures = 0;

  dma_desc_sched #(.NUM_REQ(N), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid), .i_req_desc(req_desc), .o_req_ready(req_ready),
    .o_fifo_wr_en(fifo_wr_en), .o_fifo_din(fifo_din), .i_fifo_full(fifo_full),
    .o_fifo_rd_en(fifo_rd_en), .i_fifo_dout(fifo_dout), .i_fifo_empty(fifo_empty),
    .o_dma_valid(dma_valid), .o_dma_desc(dma_desc), .o_dma_id(dma_id),
    .i_dma_ready(dma_ready), .i_dma_done(dma_done),
    .o_done_vec(done_vec), .o_drop_vec(drop_vec), .o_stray_cnt(stray_cnt),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- external FIFO (8 x 48b) ----------------
  logic [47:0] fq[$];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
    end else begin
      if (fifo_rd_en && fq.size() > 0) void'(fq.pop_front());
      if (fifo_wr_en && fq.size() < 8) fq.push_back(fifo_din);
    end
    fifo_full  <= (fq.size() == 8);
    fifo_empty <= (fq.size() == 0);
    fifo_dout  <= (fq.size() > 0) ? fq[0] : 48'd0;
  end

  // ---------------- reference model + scoreboard (sampled on negedge) ----------------
  logic [49:0]  exp_q[$];          // {id, desc} in expected DMA order
  int           m_rr;
  bit           m_off, m_busy;
  logic [1:0]   m_id;
  int           m_stray;
  logic [N-1:0] m_drop_nx, m_done_nx;
  logic [N-1:0] last_grant = '0;
  bit           last_hs = 1'b0;

  always @(negedge clk) begin
    logic [N-1:0] exp_g;
    int           win;
    logic [47:0]  d;
    logic [49:0]  e;
    logic         exp_rd;
    if (!rst_n) begin
      exp_q.delete();
      m_rr = N - 1; m_off = 0; m_busy = 0; m_id = '0; m_stray = 0;
      m_drop_nx = '0; m_done_nx = '0; last_grant = '0; last_hs = 0;
    end else begin
      chk_eq("drop_vec", drop_vec, m_drop_nx);
      chk_eq("done_vec", done_vec, m_done_nx);
      chk_eq("stray_cnt", stray_cnt, m_stray);
      chk_eq("dma_valid", dma_valid, m_off);
      m_drop_nx = '0;
      m_done_nx = '0;
      exp_g = '0;
      win = -1;
      if (!fifo_full) begin
        for (int k = 1; k <= N; k++) begin
          if (win < 0 && req_valid[(m_rr + k) % N]) win = (m_rr + k) % N;
        end
      end
      if (win >= 0) exp_g[win] = 1'b1;
      chk_eq("req_ready", req_ready, exp_g);
      last_grant = req_ready & req_valid;
      if (win >= 0) begin
        m_rr = win;
        d = req_desc[48*win +: 48];
        if (d[47:32] == 16'd0) begin
          chk_eq("wr_en_zero_len", fifo_wr_en, 1'b0);
          m_drop_nx[win] = 1'b1;
        end else begin
          chk_eq("wr_en", fifo_wr_en, 1'b1);
          chk_eq("fifo_din", fifo_din, d);
          exp_q.push_back({2'(win), d});
        end
      end else begin
        chk_eq("wr_en_no_grant", fifo_wr_en, 1'b0);
      end
      exp_rd = !m_off && !m_busy && !fifo_empty;
      chk_eq("rd_en", fifo_rd_en, exp_rd);
      if (dma_done) begin
        if (m_busy) begin
          m_done_nx[int'(m_id)] = 1'b1;
          m_busy = 0;
        end else if (m_stray < 255) begin
          m_stray++;
        end
      end
      last_hs = m_off && dma_ready;
      if (last_hs) begin
        chk_eq("dma_pending", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk_eq("dma_desc", dma_desc, e[47:0]);
          chk_eq("dma_id", dma_id, e[49:48]);
          m_id = e[49:48];
        end
        m_off = 0;
        m_busy = 1;
      end
      if (exp_rd) m_off = 1;
    end
  end

  // ---------------- random drivers ----------------
  bit req_auto = 0, eng_auto = 0, eng_busy = 0;
  int eng_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (req_auto) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || last_grant[i]) begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          req_desc[48*i +: 48] = {(($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 65535))),
                                  32'($urandom())};
        end
      end
    end
    if (eng_auto) begin
      dma_done = 1'b0;
      if (last_hs) begin
        eng_busy = 1;
        eng_cnt = $urandom_range(0, 5);
      end else if (eng_busy) begin
        if (eng_cnt == 0) begin
          dma_done = 1'b1;
          eng_busy = 0;
        end else begin
          eng_cnt--;
        end
      end else if ($urandom_range(0, 40) == 0) begin
        dma_done = 1'b1;
      end
      dma_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [15:0] len, input logic [31:0] addr);
    req_valid[i] = v;
    req_desc[48*i +: 48] = {len, addr};
  endtask

  task automatic wait_drained(input int budget);
    int n;
    n = 0;
    @(negedge clk); #2;
    while (!(exp_q.size() == 0 && !m_busy && !m_off && fifo_empty) && n < budget) begin
      @(negedge clk); #2;
      n++;
    end
    chk_eq("drain_in_budget", n < budget, 1'b1);
    eng_auto = 0;
    req_auto = 0;
    cyc();
    dma_ready = 1'b0;
    dma_done  = 1'b0;
    req_valid = '0;
    eng_busy  = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #2 rst_n = 1'b0;
    req_valid = 2'b11;
    set_req(0, 1'b1, 16'd8, 32'h10);
    set_req(1, 1'b1, 16'd8, 32'h20);
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_req_ready", req_ready, 2'b00);
    chk_eq("rst_wr_en", fifo_wr_en, 1'b0);
    chk_eq("rst_rd_en", fifo_rd_en, 1'b0);
    chk_eq("rst_dma_valid", dma_valid, 1'b0);
    chk_eq("rst_dma_desc", dma_desc, 48'd0);
    chk_eq("rst_stray", stray_cnt, 8'd0);
    req_valid = '0;
    rst_n = 1'b1;

    // stray done while idle
    dma_done = 1'b1;
    cyc();
    dma_done = 1'b0;
    @(negedge clk);
    chk_eq("stray_idle_cnt", stray_cnt, 8'd1);
    chk_eq("stray_idle_no_done", done_vec, 2'b00);

    // single descriptor latency and completion
    cyc();
    set_req(0, 1'b1, 16'd64, 32'h1000);
    @(negedge clk);
    chk_eq("t1_wr_en_c0", fifo_wr_en, 1'b1);
    chk_eq("t1_grant_c0", req_ready, 2'b01);
    cyc();
    req_valid = '0;
    @(negedge clk);
    chk_eq("t1_rd_en_c1", fifo_rd_en, 1'b1);
    chk_eq("t1_valid_c1", dma_valid, 1'b0);
    cyc();
    @(negedge clk);
    chk_eq("t1_valid_c2", dma_valid, 1'b1);
    chk_eq("t1_desc_c2", dma_desc, 48'h0040_0000_1000);
    chk_eq("t1_id_c2", dma_id, 2'd0);
    cyc();
    dma_ready = 1'b1;
    cyc();
    dma_ready = 1'b0;
    dma_done = 1'b1;
    cyc();
    dma_done = 1'b0;
    @(negedge clk);
    chk_eq("t1_done_pulse", done_vec, 2'b01);
    cyc();
    @(negedge clk);
    chk_eq("t1_done_one_cycle", done_vec, 2'b00);

    // alternating grants, fill to full with DMA stalled
    cyc();
    set_req(0, 1'b1, 16'd100, 32'h100);
    set_req(1, 1'b1, 16'd200, 32'h200);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk_eq("rr_order", req_ready, (k % 2 == 0) ? 2'b10 : 2'b01);
      cyc();
      set_req((k % 2 == 0) ? 1 : 0, 1'b1, 16'(300 + k), 32'(32'hA000 + k));
    end
    @(negedge clk);
    chk_eq("full_flag", fifo_full, 1'b1);
    chk_eq("full_no_grant", req_ready, 2'b00);
    chk_eq("full_dma_held", dma_valid, 1'b1);
    cyc();
    req_valid = '0;
    eng_auto = 1;
    wait_drained(600);

    // zero-length descriptor dropped
    set_req(1, 1'b1, 16'd0, 32'h2000);
    @(negedge clk);
    chk_eq("zl_grant", req_ready, 2'b10);
    chk_eq("zl_no_write", fifo_wr_en, 1'b0);
    cyc();
    req_valid = '0;
    @(negedge clk);
    chk_eq("zl_drop_pulse", drop_vec, 2'b10);
    cyc();
    @(negedge clk);
    chk_eq("zl_drop_one_cycle", drop_vec, 2'b00);

    // reset during ISSUE with descriptors queued
    cyc();
    for (int k = 0; k < 4; k++) begin
      set_req(0, 1'b1, 16'(k + 1), 32'(32'h3000 + k));
      cyc();
    end
    req_valid = '0;
    cyc();
    @(negedge clk);
    chk_eq("t6_in_issue", dma_valid, 1'b1);
    cyc();
    req_valid = 2'b11;
    #2 rst_n = 1'b0;
    #1;
    chk_eq("t6_rst_req_ready", req_ready, 2'b00);
    chk_eq("t6_rst_wr_en", fifo_wr_en, 1'b0);
    chk_eq("t6_rst_rd_en", fifo_rd_en, 1'b0);
    chk_eq("t6_rst_dma_valid", dma_valid, 1'b0);
    chk_eq("t6_rst_dma_desc", dma_desc, 48'd0);
    chk_eq("t6_rst_dma_id", dma_id, 2'd0);
    chk_eq("t6_rst_vecs", {done_vec, drop_vec}, 4'd0);
    chk_eq("t6_rst_stray", stray_cnt, 8'd0);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_eq("t6_first_grant_req0", req_ready, 2'b01);
    cyc();
    req_valid = '0;

    // random traffic
    eng_busy = 0;
    req_auto = 1;
    eng_auto = 1;
    repeat (3000) @(posedge clk);
    @(negedge clk); #2;
    req_auto = 0;
    req_valid = '0;
    wait_drained(2000);

    // stray counter saturation
    dma_done = 1'b1;
    repeat (300) cyc();
    dma_done = 1'b0;
    @(negedge clk);
    chk_eq("stray_saturate", stray_cnt, 8'd255);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
